// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment grade reader: active-low digit patterns,
// pattern classes and reader FSM state encoding.
package seg7_pkg;

    // bit6 = seg a ... bit0 = seg g, active-low
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_10    = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        CL_DIGIT = 2'd0,
        CL_BLANK = 2'd1,
        CL_ERRO  = 2'd2
    } seg_class_e;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSettling = 2'd1;
    localparam logic [1:0] StLocked   = 2'd2;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational decode of an active-low 7-segment pattern into a grade code
// and a class; non-digit patterns always report code 0.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0]  pattern_i,
    output logic [3:0]  code_o,
    output seg_class_e  seg_class_o
);

    always_comb begin
        code_o      = 4'd0;
        seg_class_o = CL_DIGIT;
        case (pattern_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_10:    code_o = 4'd10;
            SEG_BLANK: seg_class_o = CL_BLANK;
            default:   seg_class_o = CL_ERRO;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Loopback monitor for the score display: debounces the segment bus and
// recovers the grade, flagging blank and illegal patterns.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] s_nota,
    output logic [3:0] nota,
    output logic       nota_valid,
    output logic       apagado,
    output logic       erro,
    output logic       nota_strobe
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    logic [6:0] samp_q, samp_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] state_q, state_d;
    logic [3:0] nota_q, nota_d;
    logic       valid_q, valid_d;
    logic       apagado_q, apagado_d;
    logic       erro_q, erro_d;
    logic       strobe_q, strobe_d;

    logic [3:0] lk_code;
    seg_class_e lk_class;
    logic       changed;
    logic       accept;
    logic       any_accepted;
    logic       new_valid, new_apagado, new_erro;

    seg7_pattern_lookup u_lookup (
        .pattern_i   (samp_q),
        .code_o      (lk_code),
        .seg_class_o (lk_class)
    );

    assign changed      = (s_nota != samp_q);
    // samp_q has now been seen STABLE_CYCLES times in a row
    assign accept       = (state_q == StSettling) && (cnt_q == StableCnt);
    assign any_accepted = valid_q | apagado_q | erro_q;
    assign new_valid    = (lk_class == CL_DIGIT);
    assign new_apagado  = (lk_class == CL_BLANK);
    assign new_erro     = (lk_class == CL_ERRO);

    always_comb begin
        samp_d = s_nota;

        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= StableCnt) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        state_d = state_q;
        case (state_q)
            StIdle:     state_d = StSettling;
            // A change on the accepting edge starts the next settle immediately
            StSettling: if (accept && !changed) state_d = StLocked;
            StLocked:   if (changed) state_d = StSettling;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        nota_d    = nota_q;
        valid_d   = valid_q;
        apagado_d = apagado_q;
        erro_d    = erro_q;
        strobe_d  = 1'b0;
        if (accept) begin
            nota_d    = lk_code;
            valid_d   = new_valid;
            apagado_d = new_apagado;
            erro_d    = new_erro;
            strobe_d  = !any_accepted || (lk_code != nota_q) ||
                        ({new_valid, new_apagado, new_erro} != {valid_q, apagado_q, erro_q});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q    <= SEG_BLANK;
            cnt_q     <= 8'd0;
            state_q   <= StIdle;
            nota_q    <= 4'd0;
            valid_q   <= 1'b0;
            apagado_q <= 1'b0;
            erro_q    <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            nota_q    <= nota_d;
            valid_q   <= valid_d;
            apagado_q <= apagado_d;
            erro_q    <= erro_d;
            strobe_q  <= strobe_d;
        end
    end

    assign nota        = nota_q;
    assign nota_valid  = valid_q;
    assign apagado     = apagado_q;
    assign erro        = erro_q;
    assign nota_strobe = strobe_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: two instances (STABLE_CYCLES 4 and 1) share one input
// stream and are compared each cycle against a run-length model of that stream.
module tb_seg7_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] s_nota;

    logic [3:0] nota4, nota1;
    logic       valid4, valid1, apagado4, apagado1, erro4, erro1, strobe4, strobe1;

    seg7_reader #(.STABLE_CYCLES(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .s_nota      (s_nota),
        .nota        (nota4),
        .nota_valid  (valid4),
        .apagado     (apagado4),
        .erro        (erro4),
        .nota_strobe (strobe4)
    );

    seg7_reader #(.STABLE_CYCLES(1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .s_nota      (s_nota),
        .nota        (nota1),
        .nota_valid  (valid1),
        .apagado     (apagado1),
        .erro        (erro1),
        .nota_strobe (strobe1)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] DIGITS [11] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1000000
    };

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: samples since last reset, and expected packed outputs
    // {nota[3:0], valid, apagado, erro, strobe} per instance.
    logic [6:0] hist [$];
    int         stable_n [2] = '{4, 1};
    logic [7:0] exp_out [2] = '{8'h00, 8'h00};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    endtask

    function automatic logic [7:0] classify(input logic [6:0] p);
        for (int d = 0; d < 11; d++) begin
            if (p == DIGITS[d]) return {4'(d), 4'b1000};
        end
        if (p == 7'b1111111) return 8'b0000_0100;
        return 8'b0000_0010;
    endfunction

    // A pattern is accepted on the edge after its run of identical samples
    // reaches exactly N; strobe when the accepted value/class is new.
    task automatic model_edge(input logic [6:0] pat, input logic rst);
        int         run;
        int         last;
        logic [7:0] acc;
        if (rst) begin
            hist.delete();
            exp_out[0] = 8'h00;
            exp_out[1] = 8'h00;
            return;
        end
        run  = 0;
        last = hist.size() - 1;
        if (last >= 0) begin
            for (int i = last; i >= 0; i--) begin
                if (hist[i] != hist[last]) break;
                run++;
            end
        end
        for (int m = 0; m < 2; m++) begin
            exp_out[m][0] = 1'b0;
            if (last >= 0 && run == stable_n[m]) begin
                acc = classify(hist[last]);
                if (exp_out[m][3:1] == 3'b000 || acc[7:1] != exp_out[m][7:1]) acc[0] = 1'b1;
                exp_out[m] = acc;
            end
        end
        hist.push_back(pat);
        if (hist.size() > 64) void'(hist.pop_front());
    endtask

    task automatic step(input logic [6:0] pat, input logic rst);
        @(negedge clk);
        s_nota = pat;
        reset  = rst;
        @(posedge clk);
        model_edge(pat, rst);
        #1;
        check("dut4", {nota4, valid4, apagado4, erro4, strobe4}, exp_out[0]);
        check("dut1", {nota1, valid1, apagado1, erro1, strobe1}, exp_out[1]);
    endtask

    task automatic hold(input logic [6:0] pat, input int cycles);
        for (int i = 0; i < cycles; i++) step(pat, 1'b0);
    endtask

    initial begin
        logic [6:0] pat;
        int         sel;
        reset  = 1'b1;
        s_nota = 7'b1111111;
        step(7'b1111111, 1'b1);
        check("reset_state", {nota4, valid4, apagado4, erro4, strobe4}, 8'h00);

        // Grade 3 held: accepted on the fifth edge, strobe for one cycle
        hold(7'b0000110, 4);
        check("g3_not_yet", {nota4, valid4, apagado4, erro4, strobe4}, 8'h00);
        step(7'b0000110, 1'b0);
        check("g3_accept", {nota4, valid4, apagado4, erro4, strobe4}, 8'h39);
        step(7'b0000110, 1'b0);
        check("g3_strobe_drop", {nota4, valid4, apagado4, erro4, strobe4}, 8'h38);

        // Short glitch to 8 inside a settle of 5
        step(7'b1111111, 1'b1);
        hold(7'b0100100, 3);
        hold(7'b0000000, 1);
        hold(7'b0100100, 6);

        // Locked on 7, one-cycle blank glitch, back to 7
        step(7'b1111111, 1'b1);
        hold(7'b0001111, 6);
        hold(7'b1111111, 1);
        hold(7'b0001111, 6);
        check("g7_glitch_hold", {nota4, valid4, apagado4, erro4, strobe4}, 8'h78);

        // Every code, held 6 cycles each
        for (int p = 0; p < 128; p++) hold(7'(p), 6);

        // Locked on 10, reset pulse, reacceptance
        hold(7'b1000000, 6);
        step(7'b1000000, 1'b1);
        check("g10_reset", {nota4, valid4, apagado4, erro4, strobe4}, 8'h00);
        hold(7'b1000000, 6);

        // Fast alternation 2/9
        step(7'b1111111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            hold(7'b0010010, 2);
            hold(7'b0000100, 2);
        end

        // Randomized segments with occasional resets
        for (int s = 0; s < 600; s++) begin
            sel = $urandom_range(0, 39);
            if (sel == 0) begin
                step(7'b1111111, 1'b1);
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 6) pat = DIGITS[$urandom_range(0, 10)];
                else if (sel == 6) pat = 7'b1111111;
                else pat = 7'($urandom);
                hold(pat, $urandom_range(1, 7));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
